// File: rtl/gain_pkg.sv
// Shared types and constants for the gain_control block.
package gain_pkg;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} conv_state_t;

  localparam logic [29:0] RECIP       = 30'd549755814;
  localparam int          RECIP_SHIFT = 39;
  localparam int          GAIN_W      = 14;
  localparam logic [3:0]  MAX_DIGIT   = 4'd9;

  // Decimal digit 'pos' (0 = units) of a non-negative value.
  function automatic logic [3:0] dec_digit(input int value, input int pos);
    int v;
    v = value;
    for (int i = 0; i < pos; i++) v = v / 10;
    return 4'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// Four-digit BCD to binary converter: 4 CONV cycles then a one-cycle LOAD pulse.
// A start in any state restarts from the most significant digit.
module bcd_to_bin
  import gain_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [3:0]        i_d3,
  input  logic [3:0]        i_d2,
  input  logic [3:0]        i_d1,
  input  logic [3:0]        i_d0,
  output logic              o_done,
  output logic [GAIN_W-1:0] o_value
);

  conv_state_t       r_state, w_state_nxt;
  logic [1:0]        r_idx, w_idx_nxt;
  logic [GAIN_W-1:0] r_acc, w_acc_nxt;
  logic [3:0]        w_digit;

  always_comb begin
    case (r_idx)
      2'd0:    w_digit = i_d3;
      2'd1:    w_digit = i_d2;
      2'd2:    w_digit = i_d1;
      default: w_digit = i_d0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    o_done      = 1'b0;
    case (r_state)
      IDLE: ;
      CONV: begin
        w_acc_nxt = r_acc * GAIN_W'(10) + {{(GAIN_W-4){1'b0}}, w_digit};
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx == 2'd3) w_state_nxt = LOAD;
      end
      LOAD: begin
        // A fresh edit supersedes the value about to be loaded.
        o_done      = !i_start;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_start) begin
      w_state_nxt = CONV;
      w_idx_nxt   = 2'd0;
      w_acc_nxt   = '0;
    end
  end

  assign o_value = r_acc;

endmodule

// File: rtl/gain_control.sv
// Audio gain stage with a BCD digit editor; outWave follows inWave by exactly 3 cycles, no backpressure.
// GAIN_CONTROL_ZERO_CROSS_EN defers each gain change to a zero crossing or ZC_TIMEOUT samples.
module gain_control
  import gain_pkg::*;
#(
  parameter int DEFAULT_GAIN = 1000,
  parameter int ZC_TIMEOUT   = 1024
) (
  input  logic               clk_48,
  input  logic               reset_n,
  input  logic signed [15:0] inWave,
  input  logic               btn_next,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic signed [15:0] outWave,
  output logic               clip,
  output logic [3:0]         num3,
  output logic [3:0]         num2,
  output logic [3:0]         num1,
  output logic [3:0]         num0,
  output logic [1:0]         cursor
);

  // Button bit order: [2] next, [1] up, [0] down.
  logic [2:0]        r_sync1, r_sync2, r_btn_q;
  logic [2:0]        w_ev;
  logic              w_next_ev, w_up_ev, w_dn_ev, w_edit;
  logic [3:0]        r_num [4];
  logic [1:0]        r_cursor;
  logic [3:0]        w_sel, w_sel_inc, w_sel_dec;
  logic              w_done;
  logic [GAIN_W-1:0] w_value;
  logic [GAIN_W-1:0] r_pending, r_active;

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_btn_q <= '0;
    end else begin
      r_sync1 <= {btn_next, btn_up, btn_down};
      r_sync2 <= r_sync1;
      r_btn_q <= r_sync2;
    end
  end

  assign w_ev      = r_sync2 & ~r_btn_q;
  assign w_next_ev = w_ev[2];
  assign w_up_ev   = w_ev[1];
  assign w_dn_ev   = w_ev[0];
  assign w_edit    = w_up_ev ^ w_dn_ev;

  assign w_sel     = r_num[r_cursor];
  assign w_sel_inc = (w_sel >= MAX_DIGIT) ? 4'd0 : w_sel + 4'd1;
  assign w_sel_dec = (w_sel == 4'd0) ? MAX_DIGIT : w_sel - 4'd1;

  // The edit uses the pre-advance cursor, so next+up together edits then moves.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_num[i] <= dec_digit(DEFAULT_GAIN, i);
      r_cursor <= 2'd0;
    end else begin
      if (w_up_ev && !w_dn_ev)      r_num[r_cursor] <= w_sel_inc;
      else if (w_dn_ev && !w_up_ev) r_num[r_cursor] <= w_sel_dec;
      if (w_next_ev) r_cursor <= r_cursor + 2'd1;
    end
  end

  bcd_to_bin u_bcd_to_bin (
    .i_clk   (clk_48),
    .i_rst_n (reset_n),
    .i_start (w_edit),
    .i_d3    (r_num[3]),
    .i_d2    (r_num[2]),
    .i_d1    (r_num[1]),
    .i_d0    (r_num[0]),
    .o_done  (w_done),
    .o_value (w_value)
  );

`ifdef GAIN_CONTROL_ZERO_CROSS_EN
  localparam int ZC_W = $clog2(ZC_TIMEOUT + 1);

  logic            r_zc_wait;
  logic [ZC_W-1:0] r_zc_cnt;
  logic            r_prev_sign;
  logic            w_cross;

  assign w_cross = (inWave == 16'sd0) || (inWave[15] != r_prev_sign);

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      r_pending   <= GAIN_W'(DEFAULT_GAIN);
      r_active    <= GAIN_W'(DEFAULT_GAIN);
      r_zc_wait   <= 1'b0;
      r_zc_cnt    <= '0;
      r_prev_sign <= 1'b0;
    end else begin
      r_prev_sign <= inWave[15];
      if (w_done) begin
        r_pending <= w_value;
        r_zc_wait <= 1'b1;
        r_zc_cnt  <= '0;
      end else if (r_zc_wait) begin
        if (w_cross || r_zc_cnt == ZC_W'(ZC_TIMEOUT - 1)) begin
          r_active  <= r_pending;
          r_zc_wait <= 1'b0;
        end else begin
          r_zc_cnt <= r_zc_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic r_load_d;

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= GAIN_W'(DEFAULT_GAIN);
      r_active  <= GAIN_W'(DEFAULT_GAIN);
      r_load_d  <= 1'b0;
    end else begin
      r_load_d <= w_done;
      if (w_done)   r_pending <= w_value;
      if (r_load_d) r_active  <= r_pending;
    end
  end
`endif

  logic signed [14:0] w_gain_s;
  logic signed [30:0] r_p;
  logic        [30:0] w_abs;
  logic        [21:0] w_quot;
  logic signed [22:0] r_q;

  assign w_gain_s = $signed({1'b0, r_active});
  assign w_abs    = r_p[30] ? $unsigned(-r_p) : $unsigned(r_p);
  // Multiply by a rounded-up reciprocal: exact floor(|p|/1000) over the whole product range.
  assign w_quot   = 22'(({30'd0, w_abs} * {31'd0, RECIP}) >> RECIP_SHIFT);

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      r_p     <= '0;
      r_q     <= '0;
      outWave <= '0;
      clip    <= 1'b0;
    end else begin
      r_p <= 31'(inWave) * 31'(w_gain_s);
      r_q <= r_p[30] ? -$signed({1'b0, w_quot}) : $signed({1'b0, w_quot});
      if (r_q > 23'sd32767) begin
        outWave <= 16'sd32767;
        clip    <= 1'b1;
      end else if (r_q < -23'sd32768) begin
        outWave <= -16'sd32768;
        clip    <= 1'b1;
      end else begin
        outWave <= r_q[15:0];
        clip    <= 1'b0;
      end
    end
  end

  assign num3   = r_num[3];
  assign num2   = r_num[2];
  assign num1   = r_num[1];
  assign num0   = r_num[0];
  assign cursor = r_cursor;

endmodule

// File: tb/tb_gain_control.sv
// Directed + randomized bench for gain_control against a decimal-arithmetic reference model.
module tb_gain_control;

  logic               clk_48 = 1'b0;
  logic               reset_n;
  logic signed [15:0] inWave;
  logic               btn_next, btn_up, btn_down;
  logic signed [15:0] outWave;
  logic               clip;
  logic [3:0]         num3, num2, num1, num0;
  logic [1:0]         cursor;

  gain_control #(.DEFAULT_GAIN(1000), .ZC_TIMEOUT(1024)) dut (
    .clk_48   (clk_48),
    .reset_n  (reset_n),
    .inWave   (inWave),
    .btn_next (btn_next),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .outWave  (outWave),
    .clip     (clip),
    .num3     (num3),
    .num2     (num2),
    .num1     (num1),
    .num0     (num0),
    .cursor   (cursor)
  );

  always #5 clk_48 = ~clk_48;

  int checks   = 0;
  int failures = 0;
  int m_num [4];
  int m_cur;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_gain();
    return m_num[3] * 1000 + m_num[2] * 100 + m_num[1] * 10 + m_num[0];
  endfunction

  function automatic int ref_q(input int x, input int g);
    return (x * g) / 1000;
  endfunction

  function automatic int ref_out(input int x, input int g);
    int q;
    q = ref_q(x, g);
    if (q > 32767)  return 32767;
    if (q < -32768) return -32768;
    return q;
  endfunction

  function automatic int ref_clip(input int x, input int g);
    int q;
    q = ref_q(x, g);
    return (q > 32767 || q < -32768) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    m_num[3] = 1; m_num[2] = 0; m_num[1] = 0; m_num[0] = 0;
    m_cur = 0;
  endfunction

  function automatic void model_edit(input bit n, input bit u, input bit d);
    if (u && !d)      m_num[m_cur] = (m_num[m_cur] == 9) ? 0 : m_num[m_cur] + 1;
    else if (d && !u) m_num[m_cur] = (m_num[m_cur] == 0) ? 9 : m_num[m_cur] - 1;
    if (n) m_cur = (m_cur + 1) % 4;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_48);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic press(input bit n, input bit u, input bit d);
    btn_next = n; btn_up = u; btn_down = d;
    cyc(3);
    btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cyc(3);
    model_edit(n, u, d);
  endtask

  task automatic check_digits(input string tag);
    chk({tag, "_num3"}, int'(num3), m_num[3]);
    chk({tag, "_num2"}, int'(num2), m_num[2]);
    chk({tag, "_num1"}, int'(num1), m_num[1]);
    chk({tag, "_num0"}, int'(num0), m_num[0]);
    chk({tag, "_cursor"}, int'(cursor), m_cur);
  endtask

  // Random samples: each output must match the sample driven 3 cycles earlier.
  task automatic stream_random(input string tag, input int n);
    int hist[$];
    int x;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(7))
        0:       x = 32767;
        1:       x = -32768;
        2:       x = 0;
        default: x = int'($urandom_range(65535)) - 32768;
      endcase
      hist.push_back(x);
      inWave = 16'(x);
      @(negedge clk_48);
      if (i >= 2) begin
        chk({tag, "_out"}, int'(outWave), ref_out(hist[i-2], m_gain()));
        chk({tag, "_clip"}, int'(clip), ref_clip(hist[i-2], m_gain()));
      end
    end
  endtask

  initial begin
    int first_new;
    int bad;
    int seen_mid;

    reset_n = 1'b0;
    btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    inWave = 16'sd16000;
    model_reset();
    cyc(3);
    chk("rst_out", int'(outWave), 0);
    chk("rst_clip", int'(clip), 0);
    check_digits("rst");

    // Unity gain, constant input: zeros for two cycles, then the sample itself.
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_48);
      chk("unity_out", int'(outWave), (i < 2) ? 0 : 16000);
      chk("unity_clip", int'(clip), 0);
    end
    stream_random("unity_rand", 40);

    // Digit wrap, cursor wrap, simultaneous up/down, next with edit.
    press(0, 0, 1);
    check_digits("down_wrap");
    chk("down_wrap_num0_is9", int'(num0), 9);
    press(0, 1, 0);
    check_digits("up_wrap");
    for (int i = 0; i < 4; i++) press(1, 0, 0);
    check_digits("cursor_wrap");
    press(0, 1, 1);
    check_digits("updown_ignored");
    press(1, 1, 0);
    check_digits("next_with_up");
    cyc(20);
    stream_random("gain1001_rand", 40);

    // Reach 2,5,0,0; observe the step from 2400 to 2500 with a constant negative input.
    do_reset();
    inWave = -16'sd12345;
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    press(0, 1, 0);
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    for (int i = 0; i < 4; i++) press(0, 1, 0);
    cyc(20);
    chk("gain2400_out", int'(outWave), ref_out(-12345, m_gain()));
    btn_up = 1'b1;
    first_new = -1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_48);
      if (i == 3) btn_up = 1'b0;
      if (int'(outWave) == ref_out(-12345, 2500)) begin
        if (first_new < 0) first_new = i;
      end else if (int'(outWave) != ref_out(-12345, 2400)) begin
        bad++;
      end
    end
    model_edit(0, 1, 0);
    check_digits("gain2500");
    chk("gain2500_no_glitch", bad, 0);
    chk("gain2500_applied_in_time", (first_new > 6 && first_new < 25) ? 1 : 0, 1);
    chk("gain2500_out", int'(outWave), -30862);
    chk("gain2500_model_out", int'(outWave), ref_out(-12345, m_gain()));
    stream_random("gain2500_rand", 40);

    // Full-scale gain 9999: saturation in both directions.
    do_reset();
    press(0, 0, 1);
    press(1, 0, 0); press(0, 0, 1);
    press(1, 0, 0); press(0, 0, 1);
    press(1, 0, 0); press(0, 0, 1); press(0, 0, 1);
    check_digits("gain9999");
    cyc(20);
    inWave = 16'sd32767;
    cyc(4);
    chk("sat_pos_out", int'(outWave), 32767);
    chk("sat_pos_clip", int'(clip), 1);
    inWave = -16'sd32768;
    cyc(4);
    chk("sat_neg_out", int'(outWave), -32768);
    chk("sat_neg_clip", int'(clip), 1);
    stream_random("gain9999_rand", 40);

    // Gain 0000 silences everything.
    do_reset();
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    press(0, 0, 1);
    check_digits("gain0");
    cyc(20);
    stream_random("gain0_rand", 30);

    // Second edit during conversion: the intermediate 1001 must never reach the output.
    do_reset();
    inWave = 16'sd10000;
    cyc(20);
    chk("conv_restart_before", int'(outWave), 10000);
    seen_mid = 0;
    for (int i = 0; i < 40; i++) begin
      btn_up = (i == 0 || i == 2 || i == 3) ? 1'b1 : 1'b0;
      @(negedge clk_48);
      if (int'(outWave) == 10010) seen_mid++;
    end
    btn_up = 1'b0;
    model_edit(0, 1, 0);
    model_edit(0, 1, 0);
    check_digits("conv_restart");
    chk("conv_restart_no_mid_gain", seen_mid, 0);
    chk("conv_restart_out", int'(outWave), ref_out(10000, m_gain()));

    // Reset in the middle of a conversion: default gain and digits survive.
    btn_up = 1'b1;
    cyc(4);
    btn_up = 1'b0;
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    model_reset();
    check_digits("rst_mid_conv");
    cyc(25);
    chk("rst_mid_conv_out", int'(outWave), 10000);

`ifdef GAIN_CONTROL_ZERO_CROSS_EN
    // No crossing: the new gain waits for the timeout.
    do_reset();
    inWave = 16'sd1000;
    cyc(5);
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    btn_up = 1'b1;
    first_new = -1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk_48);
      if (i == 3) btn_up = 1'b0;
      if (i == 1000) chk("zc_hold_out", int'(outWave), 1000);
      if (first_new < 0 && int'(outWave) == 2000) first_new = i;
    end
    model_edit(0, 1, 0);
    chk("zc_timeout_window", (first_new >= 1024 && first_new < 1060) ? 1 : 0, 1);
    chk("zc_timeout_out", int'(outWave), ref_out(1000, m_gain()));

    // A sign change before the timeout applies the gain immediately.
    do_reset();
    inWave = 16'sd1000;
    cyc(5);
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    press(0, 1, 0);
    cyc(80);
    inWave = 16'sd5;
    cyc(15);
    chk("zc_pre_cross_out", int'(outWave), 5);
    inWave = -16'sd5;
    cyc(8);
    chk("zc_cross_out", int'(outWave), ref_out(-5, m_gain()));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
